// File: rtl/spi_op_pkg.sv
// Shared widths, FSM state and operand frame layout for the SPI operand loader.
package spi_op_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned FRAME_W = SEL_W + 2 * OP_W;
    // Bit counter must hold FRAME_W+1 so that long frames stay distinguishable
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [OP_W-1:0]  a;
        logic [OP_W-1:0]  b;
    } op_frame_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous level, with registered
// single-cycle rise and fall pulses derived from the synchronized value.
module sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    logic              w_level;

    assign w_level = r_sync[STAGES-1];

    // Synchronizer chain, reset to the pin's idle level so reset creates no edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= w_level;
        end
    end

    // Registered edge pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_level & ~r_prev;
            r_fall <= ~w_level & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/spi_operand_loader.sv
// SPI mode 0 slave that receives {select, a, b} MSB first, stages the frame,
// commits it to the operand registers on a confirm rising edge, and shifts
// the committed operands back out on miso during each frame.
module spi_operand_loader
    import spi_op_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sclk,
    input  logic             i_ss_n,
    input  logic             i_mosi,
    input  logic             i_confirm,
    output logic [SEL_W-1:0] o_select,
    output logic [OP_W-1:0]  o_a,
    output logic [OP_W-1:0]  o_b,
    output logic             o_frame_valid,
    output logic             o_pending,
    output logic             o_frame_err,
    output logic             o_miso
);

    // Synchronized edge events
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_conf_rise;
    logic w_conf_fall_unused;
    logic w_mosi_s;

    // FSM
    state_t r_state;
    state_t w_state_next;

    // Control strobes from the output decoder
    logic w_start;
    logic w_rx_shift;
    logic w_tx_shift;
    logic w_end_ok;
    logic w_end_err;
    logic w_commit;

    // Datapath
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [FRAME_W-1:0]     r_rx_sr;
    logic [FRAME_W-1:0]     r_tx_sr;
    logic [CNT_W-1:0]       r_bit_cnt;
    op_frame_t              r_staged;
    op_frame_t              r_commit;
    logic                   r_pending;
    logic                   r_frame_valid;
    logic                   r_frame_err;

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_sclk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_ss_n (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_ss_n),
        .o_rise (w_ss_rise),
        .o_fall (w_ss_fall)
    );

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_confirm (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_confirm),
        .o_rise (w_conf_rise),
        .o_fall (w_conf_fall_unused)
    );

    // mosi chain of equal depth so the sampled bit lines up with sclk rise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
        end
    end

    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; sclk activity is irrelevant outside a frame
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_state_next = SHIFT;
            SHIFT:   if (w_ss_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM output decode into datapath strobes
    always_comb begin
        w_start    = 1'b0;
        w_rx_shift = 1'b0;
        w_tx_shift = 1'b0;
        w_end_ok   = 1'b0;
        w_end_err  = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = w_ss_fall;
            end
            SHIFT: begin
                w_rx_shift = w_sclk_rise & ~w_ss_rise;
                w_tx_shift = w_sclk_fall & ~w_ss_rise;
                w_end_ok   = w_ss_rise & (r_bit_cnt == CNT_W'(FRAME_W));
                w_end_err  = w_ss_rise & (r_bit_cnt != CNT_W'(FRAME_W));
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // A commit only acts on a confirm edge while a frame is staged
    assign w_commit = w_conf_rise & r_pending;

    // Receive shift register and saturating bit counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
        end else if (w_start) begin
            r_bit_cnt <= '0;
        end else if (w_rx_shift) begin
            r_rx_sr <= {r_rx_sr[FRAME_W-2:0], w_mosi_s};
            if (r_bit_cnt != CNT_W'(FRAME_W + 1)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // Readback shifter: loaded at frame start, zero-fills so miso idles low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_sr <= '0;
        end else if (w_start) begin
            r_tx_sr <= r_commit;
        end else if (w_tx_shift) begin
            r_tx_sr <= {r_tx_sr[FRAME_W-2:0], 1'b0};
        end else if (w_end_ok || w_end_err) begin
            r_tx_sr <= '0;
        end
    end

    // Staging register, pending flag and frame error pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_staged    <= '0;
            r_pending   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_end_err;
            if (w_end_ok) begin
                r_staged <= op_frame_t'(r_rx_sr);
            end
            // A frame landing together with a commit keeps pending set
            if (w_end_ok) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Committed operands; take the staged value present before this edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_commit      <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_commit;
            if (w_commit) begin
                r_commit <= r_staged;
            end
        end
    end

    assign o_select      = r_commit.sel;
    assign o_a           = r_commit.a;
    assign o_b           = r_commit.b;
    assign o_frame_valid = r_frame_valid;
    assign o_pending     = r_pending;
    assign o_frame_err   = r_frame_err;
    assign o_miso        = r_tx_sr[FRAME_W-1];

endmodule
